// File: rtl/priority_encoder_display.sv
// Priority encoder with a stability filter and a registered 7-segment hex display.
// The display shows either the live stable winner or the highest stable index seen (peak hold).
module priority_encoder_display #(
  parameter int WIDTH  = 16,
  parameter int STABLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  input  logic             clear,
  output logic [6:0]       segments,
  output logic             none,
  output logic [3:0]       index,
  output logic             update
);

  localparam logic [7:0] STABLE_C = 8'(STABLE);

  logic [WIDTH-1:0] data_q;
  logic             cand_none;
  logic [3:0]       cand_idx;
  logic             prev_none;
  logic [3:0]       prev_idx;
  logic [7:0]       count;
  logic [7:0]       count_next;
  logic             same;
  logic             accept;
  logic             load;
  logic [6:0]       cand_segments;

  function automatic logic [6:0] hex7(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b0111111;
      4'h1:    pattern = 7'b0000110;
      4'h2:    pattern = 7'b1011011;
      4'h3:    pattern = 7'b1001111;
      4'h4:    pattern = 7'b1100110;
      4'h5:    pattern = 7'b1101101;
      4'h6:    pattern = 7'b1111101;
      4'h7:    pattern = 7'b0000111;
      4'h8:    pattern = 7'b1111111;
      4'h9:    pattern = 7'b1101111;
      4'hA:    pattern = 7'b1110111;
      4'hB:    pattern = 7'b1111100;
      4'hC:    pattern = 7'b0111001;
      4'hD:    pattern = 7'b1011110;
      4'hE:    pattern = 7'b1111001;
      default: pattern = 7'b1110001;
    endcase
    return pattern;
  endfunction

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    cand_none = (data_q == '0);
    cand_idx  = 4'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_q[i]) cand_idx = 4'(i);
    end
  end

  // A new candidate restarts the run at 1; acceptance fires once, on the edge the run reaches STABLE.
  always_comb begin
    same = (cand_none == prev_none) && (cand_idx == prev_idx);
    if (!same)
      count_next = 8'd1;
    else if (count < STABLE_C)
      count_next = count + 8'd1;
    else
      count_next = count;
    accept = (count_next == STABLE_C) && (!same || (count < STABLE_C));
  end

  always_comb begin
    if (mode)
      load = accept && !cand_none && (none || (cand_idx > index));
    else
      load = accept && ((cand_none != none) || (cand_idx != index));
    cand_segments = cand_none ? 7'b0000000 : hex7(cand_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      prev_none <= 1'b1;
      prev_idx  <= 4'd0;
      count     <= 8'd0;
      none      <= 1'b1;
      index     <= 4'd0;
      segments  <= 7'b0000000;
      update    <= 1'b0;
    end else begin
      data_q <= data;
      if (clear) begin
        prev_none <= 1'b1;
        prev_idx  <= 4'd0;
        count     <= 8'd0;
        none      <= 1'b1;
        index     <= 4'd0;
        segments  <= 7'b0000000;
        update    <= 1'b0;
      end else begin
        prev_none <= cand_none;
        prev_idx  <= cand_idx;
        count     <= count_next;
        update    <= load;
        if (load) begin
          none     <= cand_none;
          index    <= cand_idx;
          segments <= cand_segments;
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_display.sv
// Self-checking bench for priority_encoder_display: a reference model pushes expected outputs
// into a scoreboard queue as each input is driven, and they are popped after the clock edge.
module tb_priority_encoder_display;

  localparam int WIDTH  = 16;
  localparam int STABLE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data = '0;
  logic             mode = 1'b0;
  logic             clear = 1'b0;
  logic [6:0]       segments;
  logic             none;
  logic [3:0]       index;
  logic             update;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [15:0] m_q;
  logic        run_none;
  logic [3:0]  run_idx;
  int          run_len;
  logic        md_none;
  logic [3:0]  md_idx;
  logic        m_upd;
  int          upd_seen;

  always #5 clk = ~clk;

  priority_encoder_display #(.WIDTH(WIDTH), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .data(data), .mode(mode), .clear(clear),
    .segments(segments), .none(none), .index(index), .update(update)
  );

  function automatic logic [15:0] packOut(input logic [6:0] s, input logic n,
                                          input logic [3:0] i, input logic u);
    return {3'b000, s, n, i, u};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock of stimulus: model the edge, queue the expectation, then compare after the edge.
  task automatic applyStimulus(input logic [15:0] d, input logic m, input logic c, input logic r,
                               input string tag);
    logic        k_none;
    logic [3:0]  k_idx;
    logic [15:0] got;
    @(negedge clk);
    data = d; mode = m; clear = c; rst = r;
    k_none = (m_q == 16'h0000);
    k_idx  = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m_q[i]) begin
        k_idx = 4'(i);
        break;
      end
    end
    if (r) begin
      m_q = 16'h0000; run_none = 1'b1; run_idx = 4'd0; run_len = 0;
      md_none = 1'b1; md_idx = 4'd0; m_upd = 1'b0;
    end else begin
      m_q = d;
      if (c) begin
        run_none = 1'b1; run_idx = 4'd0; run_len = 0;
        md_none = 1'b1; md_idx = 4'd0; m_upd = 1'b0;
      end else begin
        if (k_none == run_none && k_idx == run_idx) run_len++;
        else begin
          run_none = k_none; run_idx = k_idx; run_len = 1;
        end
        m_upd = 1'b0;
        if (run_len == STABLE) begin
          if (m) begin
            if (!k_none && (md_none || k_idx > md_idx)) begin
              md_none = 1'b0; md_idx = k_idx; m_upd = 1'b1;
            end
          end else if (k_none != md_none || k_idx != md_idx) begin
            md_none = k_none; md_idx = k_idx; m_upd = 1'b1;
          end
        end
      end
    end
    exp_q.push_back(packOut(md_none ? 7'h00 : seg_tab[md_idx], md_none,
                            md_none ? 4'd0 : md_idx, m_upd));
    @(posedge clk);
    #1;
    got = packOut(segments, none, index, update);
    if (update === 1'b1) upd_seen++;
    checkOutput(tag, got, exp_q.pop_front());
  endtask

  initial begin
    logic [15:0] val;
    logic        rmode;
    int          hold;

    m_q = '0; run_none = 1'b1; run_idx = '0; run_len = 0;
    md_none = 1'b1; md_idx = '0; m_upd = 1'b0; upd_seen = 0;

    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, "reset0");
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, "reset1");
    checkOutput("reset_state", packOut(segments, none, index, update), packOut(7'h00, 1'b1, 4'd0, 1'b0));
    for (int n = 0; n < 10; n++) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, "zero_hold");
    checkOutput("zero_no_update", 16'(upd_seen), 16'd0);
    checkOutput("zero_none", {15'b0, none}, 16'd1);

    for (int n = 0; n < 4; n++) applyStimulus(16'h00A0, 1'b0, 1'b0, 1'b0, "live_a0");
    checkOutput("live_a0_not_yet", {15'b0, none}, 16'd1);
    applyStimulus(16'h00A0, 1'b0, 1'b0, 1'b0, "live_a0");
    checkOutput("live_a0_shown", packOut(segments, none, index, update), packOut(7'h07, 1'b0, 4'd7, 1'b1));
    applyStimulus(16'h00A0, 1'b0, 1'b0, 1'b0, "live_a0");
    checkOutput("live_a0_pulse_end", {15'b0, update}, 16'd0);

    for (int n = 0; n < 6; n++) applyStimulus(16'h8001, 1'b0, 1'b0, 1'b0, "glitch_pre");
    upd_seen = 0;
    applyStimulus(16'h0001, 1'b0, 1'b0, 1'b0, "glitch");
    for (int n = 0; n < 8; n++) applyStimulus(16'h8001, 1'b0, 1'b0, 1'b0, "glitch_post");
    checkOutput("glitch_no_update", 16'(upd_seen), 16'd0);
    checkOutput("glitch_index_f", packOut(segments, none, index, 1'b0), packOut(7'h71, 1'b0, 4'hF, 1'b0));

    applyStimulus(16'h0020, 1'b1, 1'b1, 1'b0, "peak_clear");
    for (int n = 0; n < 5; n++) applyStimulus(16'h0020, 1'b1, 1'b0, 1'b0, "peak_20");
    checkOutput("peak_idx5", {11'b0, none, index}, 16'h0005);
    for (int n = 0; n < 6; n++) applyStimulus(16'h0400, 1'b1, 1'b0, 1'b0, "peak_400");
    checkOutput("peak_idxA", {11'b0, none, index}, 16'h000A);
    for (int n = 0; n < 6; n++) applyStimulus(16'h0008, 1'b1, 1'b0, 1'b0, "peak_08");
    for (int n = 0; n < 6; n++) applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, "peak_00");
    checkOutput("peak_holdA", {11'b0, none, index}, 16'h000A);

    applyStimulus(16'h0004, 1'b1, 1'b1, 1'b0, "peak_clear2");
    checkOutput("clear_none", {15'b0, none}, 16'd1);
    for (int n = 0; n < 4; n++) applyStimulus(16'h0004, 1'b1, 1'b0, 1'b0, "after_clear");
    checkOutput("clear_rebuild_idx2", {11'b0, none, index}, 16'h0002);

    for (int n = 0; n < 4; n++) applyStimulus(16'h0100, 1'b0, 1'b0, 1'b0, "pre_rst");
    applyStimulus(16'h0100, 1'b0, 1'b0, 1'b1, "mid_rst");
    checkOutput("mid_rst_none", {15'b0, none}, 16'd1);
    for (int n = 0; n < 4; n++) applyStimulus(16'h0100, 1'b0, 1'b0, 1'b0, "post_rst");
    checkOutput("post_rst_still_none", {15'b0, none}, 16'd1);
    applyStimulus(16'h0100, 1'b0, 1'b0, 1'b0, "post_rst");
    checkOutput("post_rst_idx8", packOut(segments, none, index, 1'b0), packOut(7'h7F, 1'b0, 4'd8, 1'b0));

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       val = 16'h0000;
        1:       val = 16'h0001 << $urandom_range(0, 15);
        default: val = 16'($urandom);
      endcase
      rmode = 1'($urandom_range(0, 1));
      hold  = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++)
        applyStimulus(val, rmode, ($urandom_range(0, 15) == 0), ($urandom_range(0, 50) == 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder_display.md
PRIORITY_ENCODER_DISPLAY -- requirements
Module: priority_encoder_display

Interface
REQ-001 Parameter: WIDTH, default 16, number of data inputs; legal range 2..16.
REQ-002 Parameter: STABLE, default 4, consecutive cycles a candidate must persist before display; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: data  input  WIDTH  request bits; bit WIDTH-1 highest priority, bit 0 lowest.
REQ-006 Port: mode  input  1  0 = live display, 1 = peak-hold display.
REQ-007 Port: clear  input  1  synchronous clear of display and filter state.
REQ-008 Port: segments  output  7  registered 7-segment pattern, bit order gfedcba, active-high.
REQ-009 Port: none  output  1  registered decimal point; 1 = no index displayed.
REQ-010 Port: index  output  4  registered displayed index, zero-extended.
REQ-011 Port: update  output  1  one-cycle pulse, high in the first cycle a new display value is visible.

Function
REQ-012 data registered into data_q every cycle; encoder operates on data_q only.
REQ-013 Candidate: cand_none = (data_q == 0); cand_idx = position of highest set bit of data_q, 0 when cand_none.
REQ-014 Filter holds prev {none,idx} and count (8 bits); candidate differing from prev loads prev, sets count = 1.
REQ-015 Candidate equal to prev increments count, saturating at STABLE; no wrap-around.
REQ-016 Acceptance occurs on the edge count becomes STABLE (including load with count = 1 when STABLE = 1); once only per stable run.
REQ-017 Live mode: accepted value loaded into display if it differs from current display; accepted none is displayed.
REQ-018 Peak mode: accepted value loaded only if not cand_none and (display is none or cand_idx > displayed index); accepted none ignored.
REQ-019 mode change affects only later acceptances; display not altered on the switching edge.
REQ-020 Latency: data held constant from before edge k -> outputs change after edge k+STABLE.
REQ-021 update = 1 exactly in the cycle following a display load that changed the value; 0 otherwise, including re-acceptance of an identical value.
REQ-022 Decode: display none -> segments 0000000, none 1, index 0; else none 0, index = idx, segments per REQ-023.
REQ-023 Hex table gfedcba: 0 0111111, 1 0000110, 2 1011011, 3 1001111, 4 1100110, 5 1101101, 6 1111101, 7 0000111, 8 1111111, 9 1101111, A 1110111, b 1111100, C 0111001, d 1011110, E 1111001, F 1110001.
REQ-024 clear: display -> none, prev -> none, count -> 0, update -> 0; data_q still samples; clear wins over same-cycle acceptance.
REQ-025 After clear, the none candidate must rebuild count from 1; in peak mode clear restarts the peak.
REQ-026 Any single-cycle change of data_q restarts the stable run (glitch rejection); count never exceeds STABLE.

Reset
REQ-027 rst wins over clear and all other inputs.
REQ-028 Reset values: data_q 0, prev none, count 0, display none, segments 0000000, none 1, index 0, update 0.
REQ-029 Reset mid-run discards the partial stable run; filtering restarts from count 0 after release.

Verification (WIDTH=16, STABLE=4)
REQ-030 Reset, data=0x0000 held -> segments 0000000, none 1, index 0, update never pulses.
REQ-031 data=0x00A0 from edge k -> after edge k+4 index 7, segments 0000111, none 0, update high one cycle.
REQ-032 data=0x8001 held, then one-cycle 0x0001, then 0x8001 -> index stays F (1110001), no update pulse.
REQ-033 mode=1, data sequence 0x0020, 0x0400, 0x0008, 0x0000, each held 6 cycles -> index 5, then A, stays A; none stays 0.
REQ-034 mode=1 with index A displayed, clear pulse with data=0x0004 held -> none=1 next cycle; index 2 after 4 further edges.
REQ-035 rst asserted at count=3 with data=0x0100 held, released -> display none until 4 edges after release of rst, then index 8 (1111111).
